// File: rtl/inv_permute_if.sv
// Handshake and slice-memory bus of inv_permute: start/ready/done control,
// source read port and destination write port.
interface inv_permute_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              ready;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [24:0]       rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [24:0]       wr_data;

    modport master (
        input  start, rd_data,
        output ready, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data,
        input  ready, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inv_permute.sv
// Inverse Keccak pi over a slice-organised state: reads every 25-bit slice, remaps lanes, writes it back.
// Define INV_PERMUTE_OUTREG_EN to add one register stage on the write port (write latency 2, FLUSH 2 cycles).
module inv_permute #(
    parameter int SLICES = 64,
    parameter int ADDR_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    inv_permute_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN        = 2'd1,
        FLUSH      = 2'd2,
        FLUSH_LAST = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SLICES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              ready_r;
    logic              done_r;
    logic              rd_en_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [24:0]       wr_data_s;

    // out[x][y] = in[y][(2x+3y) mod 5], bit index x + 5y
    function automatic logic [24:0] inv_pi(input logic [24:0] s);
        logic [24:0] d;
        logic [4:0]  di;
        logic [4:0]  si;
        d = 25'd0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                di    = 5'(x + 5 * y);
                si    = 5'(y + 5 * ((2 * x + 3 * y) % 5));
                d[di] = s[si];
            end
        end
        return d;
    endfunction

    // Controller and slice counter; the counter doubles as the read address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            rd_en_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r <= RUN;
                        cnt_r   <= '0;
                        ready_r <= 1'b0;
                        rd_en_r <= 1'b1;
                    end else begin
                        ready_r <= 1'b1;
                        rd_en_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt_r == LAST_ADDR) begin
                        cnt_r   <= '0;
                        rd_en_r <= 1'b0;
`ifdef INV_PERMUTE_OUTREG_EN
                        state_r <= FLUSH;
`else
                        state_r <= FLUSH_LAST;
                        done_r  <= 1'b1;
`endif
                    end else begin
                        cnt_r <= cnt_r + ADDR_ONE;
                    end
                end
                FLUSH: begin
                    state_r <= FLUSH_LAST;
                    done_r  <= 1'b1;
                end
                FLUSH_LAST: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                    rd_en_r <= 1'b0;
                end
            endcase
        end
    end

    // Write stage tracks the read one cycle later, matching the synchronous read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
        end else begin
            wr_en_r   <= rd_en_r;
            wr_addr_r <= cnt_r;
        end
    end

    // Permuted data is forced to zero outside write cycles so the port is quiet when idle.
    always_comb begin
        wr_data_s = 25'd0;
        if (wr_en_r) begin
            wr_data_s = inv_pi(bus.rd_data);
        end else begin
            wr_data_s = 25'd0;
        end
    end

`ifdef INV_PERMUTE_OUTREG_EN
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [24:0]       wr_data_q;

    // Extra output register stage on the whole write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 25'd0;
        end else begin
            wr_en_q   <= wr_en_r;
            wr_addr_q <= wr_addr_r;
            wr_data_q <= wr_data_s;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
`else
    assign bus.wr_en   = wr_en_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_s;
`endif

    assign bus.ready   = ready_r;
    assign bus.done    = done_r;
    assign bus.rd_en   = rd_en_r;
    assign bus.rd_addr = cnt_r;
endmodule

// File: doc/inv_permute.md
Name: inv_permute

Overview:
- Inverse of the Keccak-style pi step, used on the decode side of the encoder pipeline.
- Walks every slice of the state held in a slice-organised source memory (one word = 25 bits = one 5x5 slice).
- Applies the inverse lane mapping within each slice and writes the result to a destination memory at the same address.
- Controlled by a start/ready handshake; internally split into a slice counter, a one-stage read/write pipeline and a small controller.

Parameters:
SLICES, 64, number of slices (words) processed per run
ADDR_W, 6, address width; must satisfy 2^ADDR_W >= SLICES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a run; sampled only while ready=1
ready  output  1  high when idle and able to accept start
done  output  1  one-cycle pulse when the last slice has been written
rd_en  output  1  source memory read enable
rd_addr  output  ADDR_W  source slice address
rd_data  input  25  source slice; valid the cycle after rd_en (synchronous read)
wr_en  output  1  destination memory write enable
wr_addr  output  ADDR_W  destination slice address
wr_data  output  25  inverse-permuted slice

Behaviour:
- Bit index within a slice: i = x + 5*y, with x,y in 0..4.
- Mapping: out[x][y] = in[y][(2x+3y) mod 5]. Equivalently, wr_data bit (x+5y) = rd_data bit (y + 5*((2x+3y) mod 5)).
- The mapping is combinational on rd_data (no state inside the datapath permutation).
- Reset values: ready=1, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0. State=IDLE, slice counter=0.
- States:
  - IDLE: ready=1. If start=1 at a clock edge, clear the counter and go to RUN.
  - RUN: ready=0, rd_en=1, rd_addr=counter; the counter increments each cycle. When counter=SLICES-1 (carry-out), go to FLUSH; the counter wraps to 0.
  - FLUSH: ready=0, rd_en=0. The final write occurs here. Next state is IDLE, and done pulses for 1 cycle in FLUSH.
- Write stage: wr_en is rd_en delayed by 1 cycle; wr_addr is rd_addr delayed by 1 cycle; wr_data is the permuted rd_data.
- Timing: start sampled at edge E0 gives reads in the cycles after E0..E(SLICES-1) and writes one cycle later each. ready returns high the cycle after FLUSH. A run is SLICES+1 busy cycles (65 by default).
- start while ready=0 is ignored; it is neither queued nor does it restart the run.
- start held high continuously: a new run begins on the first edge after ready returns to 1.
- Asynchronous rst mid-run: immediately forces the reset values and IDLE. A partially written destination is left as is; no further writes occur.
- SLICES below 2^ADDR_W: addresses SLICES..2^ADDR_W-1 are never accessed.

Optional Feature:
- Macro: INV_PERMUTE_OUTREG_EN.
- Defined:
  - wr_en, wr_addr and wr_data are each registered one extra stage, giving a write latency of 2 cycles after rd_en.
  - FLUSH lasts 2 cycles; done pulses in the second.
  - Total busy time is SLICES+2 cycles.
- Undefined: behaviour exactly as in Behaviour (write latency 1, FLUSH 1 cycle).

Test Plan:
- Reset, then idle: ready=1, all enables 0; start pulse -> ready=0 next cycle, rd_addr sequences 0..63, wr_addr 0..63 lagging by 1 cycle, done once, ready=1 after 65 busy cycles.
- Single-bit slices: rd_data=25'h0000001 -> wr_data=25'h0000001; rd_data bit1 -> wr_data bit6; rd_data bit5 -> wr_data bit3.
- Patterns: all-ones source -> all-ones destination; source slice k = k replicated -> each destination word equals the software inverse-pi of its source word.
- Round trip: run the forward permute, then inv_permute, on a random 64x25 state -> destination equals the original state bit-for-bit.
- Robustness: start pulsed at cycle 10 of a run -> no restart, addresses continue. rst asserted at cycle 30 -> outputs return to reset values immediately and no wr_en afterwards. Fresh start -> full correct run.
- With INV_PERMUTE_OUTREG_EN defined: write lag 2 cycles; done and ready=1 after 66 busy cycles; data identical to the non-registered build.
